// File: rtl/irq_queue_if.sv
// rtl/irq_queue_if.sv - request/presentation bundle between peripherals, irq_queue and the core
interface irq_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic          en;
  logic          i_req;
  logic [31:0]   i_req_r0;
  logic [31:0]   i_req_r1;
  logic          o_full;
  logic [PW-1:0] o_pending;
  logic          o_drop;
  logic          o_irq;
  logic [31:0]   o_irq_r0;
  logic [31:0]   o_irq_r1;

  modport master (
    output en, i_req, i_req_r0, i_req_r1,
    input  o_full, o_pending, o_drop, o_irq, o_irq_r0, o_irq_r1
  );

  modport slave (
    input  en, i_req, i_req_r0, i_req_r1,
    output o_full, o_pending, o_drop, o_irq, o_irq_r0, o_irq_r1
  );
endinterface

// File: rtl/irq_queue.sv
// rtl/irq_queue.sv - interrupt event FIFO replayed to the core as fixed-width, gapped irq pulses
module irq_queue #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 10,
  parameter int GAP   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  irq_queue_if.slave   bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          irq_q, irq_d;
  logic          drop_q, drop_d;
  logic [31:0]   r0_q, r0_d;
  logic [31:0]   r1_q, r1_d;
  logic [31:0]   mem_r0_q [DEPTH];
  logic [31:0]   mem_r1_q [DEPTH];

  logic [PW-1:0] pending;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  // Extra pointer bit separates full from empty; occupancy is the pointer distance.
  assign pending = wr_ptr_q - rd_ptr_q;
  assign empty   = (pending == '0);
  assign full    = (pending == PW'(DEPTH));

  // Pulse sequencer: pop/load on entry to ASSERT, count HOLD high then GAP low; en freezes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en && !empty) begin
          pop     = 1'b1;
          state_d = S_ASSERT;
          cnt_d   = CW'(HOLD - 1);
        end
      end
      S_ASSERT: begin
        if (bus.en) begin
          if (cnt_q == '0) begin
            irq_d   = 1'b0;
            cnt_d   = CW'(GAP - 1);
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_GAP: begin
        if (bus.en) begin
          if (cnt_q == '0) begin
            if (!empty) begin
              pop     = 1'b1;
              state_d = S_ASSERT;
              cnt_d   = CW'(HOLD - 1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      irq_d = 1'b1;
      r0_d  = mem_r0_q[rd_ptr_q[AW-1:0]];
      r1_d  = mem_r1_q[rd_ptr_q[AW-1:0]];
    end
  end

  // FIFO bookkeeping: a full FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    push     = bus.i_req && (!full || pop);
    drop_d   = bus.i_req && !push;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // Control and presentation registers; reset discards every queued event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      irq_q    <= 1'b0;
      drop_q   <= 1'b0;
      r0_q     <= '0;
      r1_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      irq_q    <= irq_d;
      drop_q   <= drop_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
    end
  end

  // Entry storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r0_q[wr_ptr_q[AW-1:0]] <= bus.i_req_r0;
      mem_r1_q[wr_ptr_q[AW-1:0]] <= bus.i_req_r1;
    end
  end

  assign bus.o_full    = full;
  assign bus.o_pending = pending;
  assign bus.o_drop    = drop_q;
  assign bus.o_irq     = irq_q;
  assign bus.o_irq_r0  = r0_q;
  assign bus.o_irq_r1  = r1_q;
endmodule

// File: tb/tb_irq_queue.sv
// tb/tb_irq_queue.sv - directed self-checking bench for irq_queue
module tb_irq_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  irq_queue_if #(.DEPTH(4)) bus ();

  irq_queue #(.DEPTH(4), .HOLD(10), .GAP(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    bus.i_req = 1'b0;
    bus.i_req_r0 = '0;
    bus.i_req_r1 = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    bus.i_req = 1'b1;
    bus.i_req_r0 = a;
    bus.i_req_r1 = b;
    step();
    bus.i_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", bus.o_irq); end
    checks++; if (bus.o_irq_r0 !== 32'h0) begin errors++; $display("FAIL reset_r0 got %h want 0", bus.o_irq_r0); end
    checks++; if (bus.o_irq_r1 !== 32'h0) begin errors++; $display("FAIL reset_r1 got %h want 0", bus.o_irq_r1); end
    checks++; if (bus.o_pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus.o_pending); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.o_full); end
    checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", bus.o_drop); end
  endtask

  task automatic test_single();
    int hi;
    int bad;
    do_reset();
    bus.en = 1'b1;
    push_one(32'h01234567, 32'h89ABCDEF);
    checks++; if (bus.o_irq !== 1'b0 || bus.o_pending !== 3'd1) begin errors++; $display("FAIL single_after_push irq %0b pend %0d want 0/1", bus.o_irq, bus.o_pending); end
    step();
    checks++; if (bus.o_irq !== 1'b1) begin errors++; $display("FAIL single_rise got %0b want 1", bus.o_irq); end
    checks++; if (bus.o_pending !== 3'd0) begin errors++; $display("FAIL single_pending got %0d want 0", bus.o_pending); end
    checks++; if (bus.o_irq_r0 !== 32'h01234567 || bus.o_irq_r1 !== 32'h89ABCDEF) begin errors++; $display("FAIL single_args got %h/%h want 01234567/89abcdef", bus.o_irq_r0, bus.o_irq_r1); end
    hi = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_irq_r0 !== 32'h01234567 || bus.o_irq_r1 !== 32'h89ABCDEF) bad++;
      if (bus.o_irq) hi++;
      else break;
    end
    checks++; if (hi !== 10) begin errors++; $display("FAIL single_hold got %0d want 10", hi); end
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.o_irq !== 1'b0) bad++;
      if (bus.o_irq_r0 !== 32'h01234567 || bus.o_irq_r1 !== 32'h89ABCDEF) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_stable_after got %0d bad samples want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v0 [3];
    int t [3];
    int n;
    logic prev;
    v0[0] = 32'hA0000001; v0[1] = 32'hA0000002; v0[2] = 32'hA0000003;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_one(v0[k], ~v0[k]);
      checks++; if (bus.o_pending !== 3'(k + 1)) begin errors++; $display("FAIL b2b_fill%0d got %0d want %0d", k, bus.o_pending, k + 1); end
    end
    bus.en = 1'b1;
    step();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_pending !== 3'd2) begin errors++; $display("FAIL b2b_first irq %0b pend %0d want 1/2", bus.o_irq, bus.o_pending); end
    t[0] = cyc; t[1] = 0; t[2] = 0;
    checks++; if (bus.o_irq_r0 !== v0[0] || bus.o_irq_r1 !== ~v0[0]) begin errors++; $display("FAIL b2b_args0 got %h want %h", bus.o_irq_r0, v0[0]); end
    n = 1;
    prev = 1'b1;
    for (int i = 0; i < 100 && n < 3; i++) begin
      step();
      if (bus.o_irq && !prev) begin
        t[n] = cyc;
        checks++; if (bus.o_irq_r0 !== v0[n] || bus.o_irq_r1 !== ~v0[n]) begin errors++; $display("FAIL b2b_args%0d got %h want %h", n, bus.o_irq_r0, v0[n]); end
        n++;
      end
      prev = bus.o_irq;
    end
    checks++; if (t[1] - t[0] !== 26) begin errors++; $display("FAIL b2b_period1 got %0d want 26", t[1] - t[0]); end
    checks++; if (t[2] - t[1] !== 26) begin errors++; $display("FAIL b2b_period2 got %0d want 26", t[2] - t[1]); end
  endtask

  task automatic test_stall();
    int r, f, r2;
    logic prev;
    do_reset();
    push_one(32'h5A5A0001, 32'h1);
    push_one(32'h5A5A0002, 32'h2);
    bus.en = 1'b1;
    step();
    r = cyc; f = 0; r2 = 0;
    prev = bus.o_irq;
    for (int i = 0; i < 60 && r2 == 0; i++) begin
      step();
      if (!bus.o_irq && prev && f == 0) f = cyc;
      if (bus.o_irq && !prev) r2 = cyc;
      prev = bus.o_irq;
      if (cyc - r == 3) bus.en = 1'b0;
      if (cyc - r == 10) bus.en = 1'b1;
    end
    checks++; if (f - r !== 17) begin errors++; $display("FAIL stall_hold got %0d want 17", f - r); end
    checks++; if (r2 - f !== 16) begin errors++; $display("FAIL stall_gap got %0d want 16", r2 - f); end
  endtask

  task automatic test_drop();
    int n;
    logic prev;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_one(32'hD0 + k, 32'hE0 + k);
      if (k == 3) begin
        checks++; if (bus.o_full !== 1'b1 || bus.o_pending !== 3'd4) begin errors++; $display("FAIL drop_full got full %0b pend %0d want 1/4", bus.o_full, bus.o_pending); end
        checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL drop_early got %0b want 0", bus.o_drop); end
      end
    end
    checks++; if (bus.o_drop !== 1'b1 || bus.o_pending !== 3'd4) begin errors++; $display("FAIL drop_pulse got drop %0b pend %0d want 1/4", bus.o_drop, bus.o_pending); end
    step();
    checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL drop_width got %0b want 0", bus.o_drop); end
    bus.en = 1'b1;
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.o_irq && !prev) begin
        checks++; if (bus.o_irq_r0 !== 32'hD0 + n) begin errors++; $display("FAIL drop_order%0d got %h want %h", n, bus.o_irq_r0, 32'hD0 + n); end
        n++;
      end
      prev = bus.o_irq;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL drop_pulses got %0d want 4", n); end
  endtask

  task automatic test_full_pop_push();
    int r;
    do_reset();
    for (int k = 0; k < 4; k++) push_one(32'hF0 + k, 32'h0);
    bus.en = 1'b1;
    step();
    r = cyc;
    checks++; if (bus.o_pending !== 3'd3) begin errors++; $display("FAIL fpp_pop got %0d want 3", bus.o_pending); end
    push_one(32'hF4, 32'h0);
    checks++; if (bus.o_pending !== 3'd4 || bus.o_full !== 1'b1) begin errors++; $display("FAIL fpp_refill got pend %0d full %0b want 4/1", bus.o_pending, bus.o_full); end
    while (cyc < r + 25) step();
    push_one(32'hF5, 32'h0);
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_r0 !== 32'hF1) begin errors++; $display("FAIL fpp_rise got irq %0b r0 %h want 1/f1", bus.o_irq, bus.o_irq_r0); end
    checks++; if (bus.o_pending !== 3'd4) begin errors++; $display("FAIL fpp_pending got %0d want 4", bus.o_pending); end
    checks++; if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL fpp_drop got %0b want 0", bus.o_drop); end
  endtask

  task automatic test_reset_mid();
    int rises;
    logic prev;
    do_reset();
    for (int k = 0; k < 3; k++) push_one(32'hC0 + k, 32'hC1);
    bus.en = 1'b1;
    step();
    step();
    step();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_pending !== 3'd2) begin errors++; $display("FAIL rmid_pre got irq %0b pend %0d want 1/2", bus.o_irq, bus.o_pending); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_irq !== 1'b0 || bus.o_irq_r0 !== 32'h0 || bus.o_irq_r1 !== 32'h0) begin errors++; $display("FAIL rmid_clear got irq %0b r0 %h r1 %h want 0", bus.o_irq, bus.o_irq_r0, bus.o_irq_r1); end
    checks++; if (bus.o_pending !== 3'd0) begin errors++; $display("FAIL rmid_pending got %0d want 0", bus.o_pending); end
    step();
    rst_n = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.o_irq && !prev) rises++;
      prev = bus.o_irq;
    end
    checks++; if (rises !== 0) begin errors++; $display("FAIL rmid_quiet got %0d pulses want 0", rises); end
    push_one(32'hBEEF, 32'h0);
    step();
    checks++; if (bus.o_irq !== 1'b1 || bus.o_irq_r0 !== 32'hBEEF) begin errors++; $display("FAIL rmid_new got irq %0b r0 %h want 1/beef", bus.o_irq, bus.o_irq_r0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_drop();
    test_full_pop_push();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
